// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, oversampling ratio and divider helper
package uart_pkg;
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] STOP  = 3'd3;
   localparam logic [2:0] BREAK = 3'd4;
   localparam int OVERSAMPLE = 16;
   function automatic int calc_div(input int sys_freq, input int baud_rate);
      return sys_freq / (baud_rate * OVERSAMPLE);
   endfunction
endpackage

// File: rtl/uart_rx_tick_gen.sv
// uart_rx_tick_gen: one-clk tick at 16x the baud rate from the system clock
module uart_rx_tick_gen
   import uart_pkg::*;
#(
   parameter int sys_freq  = 100_000_000,
   parameter int BAUD_rate = 9600
) (
   input  logic clk,
   input  logic reset_p,
   output logic tick
);
   localparam int DIV = calc_div(sys_freq, BAUD_rate);
   localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;
   logic [CW-1:0] cnt;
   assign tick = cnt == CW'(DIV - 1);
   always_ff @(posedge clk)
      cnt <= (reset_p || tick) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 16x oversampled on the system clock
module uart_rx
   import uart_pkg::*;
#(
   parameter int sys_freq  = 100_000_000,
   parameter int BAUD_rate = 9600
) (
   input  logic       clk,
   input  logic       reset_p,
   input  logic       rx,
   output logic [7:0] data_o,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);
   logic       tick;
   logic       rx_m;
   logic       rx_s;
   logic [2:0] state;
   logic [2:0] state_next;
   logic [3:0] samp;
   logic [2:0] bcnt;
   logic [7:0] shreg;
   logic       good;
   logic       bad;
   uart_rx_tick_gen #(.sys_freq(sys_freq), .BAUD_rate(BAUD_rate)) u_tick (
      .clk(clk),
      .reset_p(reset_p),
      .tick(tick)
   );
   // synchronizer presets high so reset never looks like a start bit
   always_ff @(posedge clk)
      {rx_m, rx_s} <= reset_p ? 2'b11 : {rx, rx_m};
   always_ff @(posedge clk)
      state <= reset_p ? IDLE : state_next;
   always_comb begin
      state_next = state;
      if (tick)
         case (state)
            IDLE:    state_next = rx_s ? IDLE : START;
            START:   state_next = samp != 4'd7 ? START : rx_s ? IDLE : DATA;
            DATA:    state_next = (samp == 4'd15 && bcnt == 3'd7) ? STOP : DATA;
            STOP:    state_next = samp != 4'd15 ? STOP : rx_s ? IDLE : BREAK;
            BREAK:   state_next = rx_s ? IDLE : BREAK;
            default: state_next = IDLE;
         endcase
   end
   always_comb begin
      good = tick && state == STOP && samp == 4'd15 && rx_s;
      bad  = tick && state == STOP && samp == 4'd15 && !rx_s;
   end
   // sample counter wraps 15->0 by itself in DATA and STOP
   always_ff @(posedge clk) begin
      if (reset_p) begin
         samp      <= '0;
         bcnt      <= '0;
         shreg     <= '0;
         data_o    <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         valid     <= good;
         frame_err <= bad;
         busy      <= state_next != IDLE;
         if (good)
            data_o <= shreg;
         if (tick) begin
            samp <= (state == IDLE || state == BREAK || (state == START && samp == 4'd7)) ? 4'd0 : samp + 4'd1;
            if (state == START)
               bcnt <= '0;
            if (state == DATA && samp == 4'd15) begin
               shreg[bcnt] <= rx_s;
               bcnt        <= bcnt + 3'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames against a frame-level reference model
module tb_uart_rx;
   logic       clk = 1'b0;
   logic       reset_p;
   logic       rx;
   logic [7:0] data_o;
   logic       valid;
   logic       frame_err;
   logic       busy;
   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int ferr_cnt = 0;
   int busy_cycles = 0;
   int both_cnt = 0;
   int dbl_cnt = 0;
   logic prev_valid = 1'b0;
   logic prev_ferr = 1'b0;
   logic [7:0] vdata[$];
   int         vcyc[$];
   logic [7:0] exp_q[$];
   int         exp_ferr = 0;
   logic [7:0] last_good = 8'h00;

   uart_rx #(.sys_freq(1_600_000), .BAUD_rate(100_000)) dut (
      .clk(clk),
      .reset_p(reset_p),
      .rx(rx),
      .data_o(data_o),
      .valid(valid),
      .frame_err(frame_err),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (valid) begin
         vdata.push_back(data_o);
         vcyc.push_back(cyc);
      end
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if (busy) busy_cycles <= busy_cycles + 1;
      if (valid && frame_err) both_cnt <= both_cnt + 1;
      if ((valid && prev_valid) || (frame_err && prev_ferr)) dbl_cnt <= dbl_cnt + 1;
      prev_valid <= valid;
      prev_ferr  <= frame_err;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // a complete frame yields its byte if the stop bit is high, else one framing error
   task automatic send_frame(input logic [7:0] d, input logic stop, input int nbits = 10);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         rx = f[i];
         repeat (16) @(negedge clk);
      end
      if (nbits == 10) begin
         if (stop) begin
            exp_q.push_back(d);
            last_good = d;
         end else
            exp_ferr++;
      end
   endtask

   task automatic verify(input string tag);
      check({tag, "_count"}, vdata.size(), exp_q.size());
      check({tag, "_ferr"}, ferr_cnt, exp_ferr);
      while (vdata.size() > 0 && exp_q.size() > 0)
         check({tag, "_data"}, vdata.pop_front(), exp_q.pop_front());
      vdata.delete();
      vcyc.delete();
      exp_q.delete();
   endtask

   initial begin
      int t0;
      int lat;
      int bc;
      logic [7:0] d;
      rx = 1'b1;
      reset_p = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_data", data_o, 8'h00);
      check("rst_valid", valid, 1'b0);
      check("rst_ferr", frame_err, 1'b0);
      check("rst_busy", busy, 1'b0);
      reset_p = 1'b0;
      idle(10);

      t0 = cyc;
      send_frame(8'hA5, 1'b1);
      idle(20);
      lat = vcyc.size() > 0 ? vcyc[vcyc.size() - 1] - t0 : -1;
      check("a5_latency", lat >= 150 && lat <= 158, 1'b1);
      check("a5_busy", busy, 1'b0);
      check("a5_data_o", data_o, 8'hA5);
      verify("a5");

      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(20);
      check("b2b_spacing", vcyc.size() >= 2 ? vcyc[vcyc.size() - 1] - vcyc[vcyc.size() - 2] : -1, 160);
      verify("b2b");

      for (int i = 0; i < 8; i++) begin
         d = 8'($urandom);
         send_frame(d, 1'b1);
         idle(16 * $urandom_range(0, 3));
      end
      idle(20);
      verify("rand");

      bc = busy_cycles;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      idle(30);
      check("glitch_busy_len", (busy_cycles - bc) >= 1 && (busy_cycles - bc) <= 8, 1'b1);
      check("glitch_busy", busy, 1'b0);
      verify("glitch");

      send_frame(8'h3C, 1'b0);
      repeat (40) @(negedge clk);
      idle(30);
      check("ferr_hold_data", data_o, last_good);
      check("ferr_busy", busy, 1'b0);
      verify("ferr");
      send_frame(8'h5A, 1'b1);
      idle(20);
      check("after_ferr_data_o", data_o, 8'h5A);
      verify("after_ferr");

      send_frame(8'h81, 1'b1, 5);
      rx = 1'b0;
      repeat (8) @(negedge clk);
      reset_p = 1'b1;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_busy", busy, 1'b0);
      check("midrst_data", data_o, 8'h00);
      reset_p = 1'b0;
      last_good = 8'h00;
      ferr_cnt = 0;
      exp_ferr = 0;
      idle(20);
      verify("midrst");
      send_frame(8'h42, 1'b1);
      idle(20);
      check("after_rst_data_o", data_o, 8'h42);
      verify("after_rst");

      check("valid_ferr_overlap", both_cnt, 0);
      check("pulse_width", dbl_cnt, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver: the receive-side counterpart of the team's UART transmitter (8N1, LSB first, idle-high line).
- Runs entirely on the system clock. It oversamples the RsRx pin at 16x the baud rate and does not use a derived UART clock.
- Delivers each received byte as a one-cycle valid pulse plus the byte, and flags framing errors.
- Sits beside the TX path in the top level. Drives LEDs or a loopback into the transmitter.

Parameters:
- sys_freq, 100_000_000, system clock frequency in Hz.
- BAUD_rate, 9600, line rate in bit/s.
- Derived constant DIV = sys_freq / (BAUD_rate*16), integer truncation (651 at defaults). DIV must be >= 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_p  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line (board pin RsRx).
- data_o  output  8  last received byte.
- valid  output  1  one-cycle pulse when data_o updates with a good frame.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (reset_p=1 at a clk edge):
  - data_o=0, valid=0, frame_err=0, busy=0, state=IDLE.
  - Synchronizer flops preset to 1; tick counter=0, sample counter=0, bit counter=0.
  - Reset mid-frame abandons the frame. No valid is produced for it.
- Input sync: two flops on rx give rx_s. All decisions use rx_s, which adds 2 clk of latency.
- Tick: free-running counter 0..DIV-1. tick=1 for one clk when the counter equals DIV-1, then it wraps to 0.
- FSM: all transitions and counter updates occur only on tick cycles, except the pulse clears.
  - IDLE: rx_s==0 on a tick -> START, sample counter=0.
  - START: count ticks. When the sample counter reaches 7 (mid start bit), check rx_s:
    - rx_s==0 -> DATA, sample counter=0, bit counter=0.
    - rx_s==1 -> IDLE (glitch rejected, no outputs).
  - DATA: on each sample counter==15, shift rx_s into the shift register at bit[bit counter] (LSB first) and clear the sample counter. After bit counter 7 is sampled -> STOP.
  - STOP: on sample counter==15:
    - rx_s==1 -> data_o=shift register, valid=1 for exactly one clk, go to IDLE.
    - rx_s==0 -> frame_err=1 for one clk, data_o unchanged, go to BREAK.
  - BREAK: wait for rx_s==1 on a tick, then go to IDLE. This prevents a held-low line from being read as repeated frames.
- valid and frame_err are never both 1. Each is high for exactly one clk cycle, not one tick.
- busy = (state != IDLE), registered.
- Latency: valid rises about 9.5 bit periods (152 ticks) after the falling edge of the start bit, +2 clk sync, +0..DIV-1 clk tick phase.
- Back-to-back frames: a start bit immediately after the stop sample is detected on the next tick after returning to IDLE. Full line rate is sustained.
- No ready input. The consumer must take data_o on the valid pulse. data_o holds its value until the next good frame.

Decomposition:
- Package uart_pkg:
  - state encoding localparams IDLE, START, DATA, STOP, BREAK (3-bit);
  - OVERSAMPLE=16;
  - function or macro for DIV.
- Sub-module uart_rx_tick_gen (params sys_freq, BAUD_rate; ports clk, reset_p, tick). Shared later with a 16x-tick version of the TX path.
- The FSM, synchronizer, and shift register stay in uart_rx.

Test Plan:
- Bench parameters: sys_freq=1_600_000, BAUD_rate=100_000, so DIV=1 (tick every clk, 1 bit = 16 clk).
- Reset: hold reset_p 3 clk with rx=1 -> data_o=0x00, valid=0, frame_err=0, busy=0.
- Good frame: send 0xA5 (start, 1,0,1,0,0,1,0,1 LSB first, stop) -> a single valid pulse with data_o=0xA5, busy low again after about 152 clk. No frame_err.
- Back-to-back: send 0x00 then 0xFF with no idle gap -> two valid pulses 160 clk apart, data_o 0x00 then 0xFF.
- Glitch: a 4-clk low pulse on an idle line -> FSM returns to IDLE. No valid or frame_err. busy high for 8 ticks or fewer.
- Framing error: send 0x3C with the stop bit driven low, then hold low 40 clk and release -> one frame_err pulse, data_o keeps its prior value, no valid. Next good frame 0x5A is received correctly.
- Reset mid-frame: assert reset_p during bit 4 of 0x81, then release and send 0x42 -> no valid for 0x81, then valid with data_o=0x42.
